// File: rtl/ttt_move_commit.sv
// Tic-tac-toe board writer and turn sequencer: commits legal one-hot moves, alternates turns, detects win/draw.
// Move ack/nack one cycle after place; player line returns two cycles after a committed place; no backpressure.
module ttt_move_commit #(
  parameter int FIRST_PLAYER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       place,
  input  logic [8:0] cur_pos,
  input  logic       illegal,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       player1,
  output logic       player2,
  output logic       move_ack,
  output logic       move_nack,
  output logic [3:0] move_count,
  output logic [1:0] winner,
  output logic       draw,
  output logic       game_over
);

  typedef enum logic [1:0] {
    P1_TURN = 2'd0,
    P2_TURN = 2'd1,
    EVAL    = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam state_t     START_STATE = (FIRST_PLAYER == 2) ? P2_TURN : P1_TURN;
  localparam logic [3:0] MAX_MOVES   = 4'd9;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_board [9];
  logic [1:0] w_board_nxt [9];
  logic [3:0] r_count;
  logic [3:0] w_count_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [1:0] r_winner;
  logic [1:0] w_winner_nxt;
  logic       r_draw;
  logic       w_draw_nxt;
  logic       r_ack;
  logic       w_ack_nxt;
  logic       r_nack;
  logic       w_nack_nxt;

  logic       w_onehot;
  logic       w_occupied;
  logic       w_legal;
  logic [1:0] w_mover;
  logic       w_win;

  function automatic logic f_line(input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] c, input logic [1:0] code);
    return (a == code) && (b == code) && (c == code);
  endfunction

  // Onehot and occupancy are re-checked here so a stale or wrong illegal flag cannot corrupt the board.
  always_comb begin
    w_onehot   = (cur_pos != 9'd0) && ((cur_pos & (cur_pos - 9'd1)) == 9'd0);
    w_occupied = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (cur_pos[i] && (r_board[i] != 2'b00)) begin
        w_occupied = 1'b1;
      end
    end
    w_legal = !illegal && w_onehot && !w_occupied;
    w_mover = (r_state == P1_TURN) ? 2'b01 : 2'b10;
    w_win   = f_line(r_board[0], r_board[1], r_board[2], r_last) |
              f_line(r_board[3], r_board[4], r_board[5], r_last) |
              f_line(r_board[6], r_board[7], r_board[8], r_last) |
              f_line(r_board[0], r_board[3], r_board[6], r_last) |
              f_line(r_board[1], r_board[4], r_board[7], r_last) |
              f_line(r_board[2], r_board[5], r_board[8], r_last) |
              f_line(r_board[0], r_board[4], r_board[8], r_last) |
              f_line(r_board[2], r_board[4], r_board[6], r_last);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_board_nxt  = r_board;
    w_count_nxt  = r_count;
    w_last_nxt   = r_last;
    w_winner_nxt = r_winner;
    w_draw_nxt   = r_draw;
    w_ack_nxt    = 1'b0;
    w_nack_nxt   = 1'b0;

    if (new_game) begin
      w_state_nxt  = START_STATE;
      for (int i = 0; i < 9; i++) begin
        w_board_nxt[i] = 2'b00;
      end
      w_count_nxt  = 4'd0;
      w_last_nxt   = 2'b00;
      w_winner_nxt = 2'b00;
      w_draw_nxt   = 1'b0;
    end else begin
      case (r_state)
        P1_TURN, P2_TURN: begin
          if (place) begin
            if (w_legal) begin
              for (int i = 0; i < 9; i++) begin
                if (cur_pos[i]) begin
                  w_board_nxt[i] = w_mover;
                end
              end
              if (r_count < MAX_MOVES) begin
                w_count_nxt = r_count + 4'd1;
              end
              w_last_nxt  = w_mover;
              w_state_nxt = EVAL;
              w_ack_nxt   = 1'b1;
            end else begin
              w_nack_nxt = 1'b1;
            end
          end
        end
        // A win takes precedence over a full board, so a 9th-move win is never a draw.
        EVAL: begin
          if (w_win) begin
            w_winner_nxt = r_last;
            w_state_nxt  = OVER;
          end else if (r_count == MAX_MOVES) begin
            w_draw_nxt  = 1'b1;
            w_state_nxt = OVER;
          end else begin
            w_state_nxt = (r_last == 2'b01) ? P2_TURN : P1_TURN;
          end
        end
        OVER: begin
          if (place) begin
            w_nack_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = START_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= START_STATE;
      for (int i = 0; i < 9; i++) begin
        r_board[i] <= 2'b00;
      end
      r_count  <= 4'd0;
      r_last   <= 2'b00;
      r_winner <= 2'b00;
      r_draw   <= 1'b0;
      r_ack    <= 1'b0;
      r_nack   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      for (int i = 0; i < 9; i++) begin
        r_board[i] <= w_board_nxt[i];
      end
      r_count  <= w_count_nxt;
      r_last   <= w_last_nxt;
      r_winner <= w_winner_nxt;
      r_draw   <= w_draw_nxt;
      r_ack    <= w_ack_nxt;
      r_nack   <= w_nack_nxt;
    end
  end

  assign pos1       = r_board[0];
  assign pos2       = r_board[1];
  assign pos3       = r_board[2];
  assign pos4       = r_board[3];
  assign pos5       = r_board[4];
  assign pos6       = r_board[5];
  assign pos7       = r_board[6];
  assign pos8       = r_board[7];
  assign pos9       = r_board[8];
  assign player1    = (r_state == P1_TURN);
  assign player2    = (r_state == P2_TURN);
  assign game_over  = (r_state == OVER);
  assign move_ack   = r_ack;
  assign move_nack  = r_nack;
  assign move_count = r_count;
  assign winner     = r_winner;
  assign draw       = r_draw;

endmodule
